serial_word_checker: RTL

- Receive-side counterpart to the serial bit stimulus that drives our single-bit flip-flop datapath.
- Samples a serial `data_in` stream MSB-first, deserializes it into WORD_W-bit words, and presents each word on a valid/ready output.
- Compares each word against an expected pattern and keeps a saturating mismatch counter.
- Sits at the output of serial datapaths and acts as the capture/check end of the bit stream.

---
 rtl/serial_word_checker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_word_checker.sv
// serial_word_checker
//   Deserializes an MSB-first serial bit stream into WORD_W-bit words,
//   presents each word on a valid/ready output slot, compares it against
//   PATTERN and keeps a saturating mismatch counter.
//
//   Build option: define SERIAL_WORD_PARITY_EN to expect one even-parity
//   bit after every data word (frame = WORD_W + 1 bits). Without it the
//   frame is WORD_W bits and parity_err is tied low.
module serial_word_checker #(
   parameter int                WORD_W  = 8,
   parameter logic [WORD_W-1:0] PATTERN = WORD_W'(8'hA5),
   parameter int                CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              data_in,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              match,
   output logic [CNT_W-1:0]  mismatch_count,
   output logic              overflow,
   output logic              parity_err
);

   // bit_cnt counts data bits already captured in the current word
   localparam int              BW       = $clog2(WORD_W + 1);
   localparam logic [BW-1:0]   LAST_IDX = BW'(WORD_W - 1);

`ifdef SERIAL_WORD_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t            state, nxt_state;
   logic [BW-1:0]     bit_cnt;
   logic [WORD_W-1:0] shift_reg;

   logic [WORD_W-1:0] shift_nxt;   // shift_reg with the current bit appended
   logic              last_data;   // this edge samples the final data bit
   logic              word_done;   // a complete frame is accepted on this edge
   logic [WORD_W-1:0] word_val;    // the word carried by that frame
   logic              slot_free;   // output slot can take a word this edge
   logic              do_load;
   logic              do_drop;
`ifdef SERIAL_WORD_PARITY_EN
   logic              par_bad;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt_state;
   end

   // Next-state logic: dropping enable mid-frame always aborts to IDLE
   always_comb begin
      nxt_state = state;
      unique case (state)
         IDLE: begin
            if (enable) nxt_state = SHIFT;
         end
         SHIFT: begin
            if (!enable) nxt_state = IDLE;
`ifdef SERIAL_WORD_PARITY_EN
            else if (bit_cnt == LAST_IDX) nxt_state = PARITY;
`endif
         end
`ifdef SERIAL_WORD_PARITY_EN
         PARITY: begin
            if (!enable) nxt_state = IDLE;
            else         nxt_state = SHIFT;
         end
`endif
         default: nxt_state = IDLE;
      endcase
   end

   // Frame-completion decode and output-slot arbitration
   always_comb begin
      shift_nxt = {shift_reg[WORD_W-2:0], data_in};
      last_data = (state == SHIFT) && enable && (bit_cnt == LAST_IDX);
`ifdef SERIAL_WORD_PARITY_EN
      // word was fully shifted in on the previous edge; data_in is parity
      word_done = (state == PARITY) && enable;
      word_val  = shift_reg;
      par_bad   = ^{shift_reg, data_in};
`else
      word_done = last_data;
      word_val  = shift_nxt;
`endif
      // a consume on this same edge frees the slot for the new word
      slot_free = !word_valid || word_ready;
      do_load   = word_done && slot_free;
      do_drop   = word_done && !slot_free;
   end

   // Deserializer: capture bits while enabled, clear the count on abort
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) begin
                  shift_reg <= {{(WORD_W-1){1'b0}}, data_in};
                  bit_cnt   <= BW'(1);
               end
            end
            SHIFT: begin
               if (enable) begin
                  shift_reg <= shift_nxt;
                  // restart at 0 after the last data bit so words run gapless
                  bit_cnt   <= last_data ? '0 : bit_cnt + 1'b1;
               end else begin
                  bit_cnt   <= '0;
               end
            end
            default: begin
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Output slot: load on a free slot, otherwise drop and flag overflow
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_out   <= '0;
         word_valid <= 1'b0;
         match      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         match <= 1'b0;
         if (do_load) begin
            word_out   <= word_val;
            word_valid <= 1'b1;
            match      <= (word_val == PATTERN);
         end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end
         if (do_drop) overflow <= 1'b1;
      end
   end

   // Mismatch counter: only loaded words count, and it sticks at all-ones
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mismatch_count <= '0;
      end else if (do_load && (word_val != PATTERN) && (mismatch_count != '1)) begin
         mismatch_count <= mismatch_count + 1'b1;
      end
   end

`ifdef SERIAL_WORD_PARITY_EN
   // Sticky parity error; the word itself is still delivered
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  parity_err <= 1'b0;
      else if (word_done && par_bad) parity_err <= 1'b1;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
